// File: rtl/opamp_loop_sequencer_if.sv
// Loop-side bus of the op-amp sequencer: control pulses, reference/feedback samples and the filter drive.
interface opamp_loop_sequencer_if #(
   parameter int W = 22
);
   logic                run;
   logic                step;
   logic                ovr_clr;
   logic signed [W-1:0] non_inv;
   logic signed [W-1:0] filt_y;
   logic signed [W-1:0] filt_x;
   logic                filt_en;
   logic                busy;
   logic                overrun;

   modport master (
      input  run, step, ovr_clr, non_inv, filt_y,
      output filt_x, filt_en, busy, overrun
   );

   modport slave (
      output run, step, ovr_clr, non_inv, filt_y,
      input  filt_x, filt_en, busy, overrun
   );
endinterface

// File: rtl/opamp_loop_sequencer.sv
// Loop-tick scheduler sharing one signed multiplier; tick-to-filt_en latency 5 cycles, no backpressure
// (ticks while busy are dropped and flagged in overrun). OPAMP_SEQ_SAT_EN selects saturating narrowing.
module opamp_loop_sequencer #(
   parameter int C_WIDTH = 16,
   parameter int DIV     = 500,
   parameter int GAIN    = 100
) (
   input  logic                   clk,
   input  logic                   reset_n,
   opamp_loop_sequencer_if.master bus
);
   localparam int W  = C_WIDTH + 6;
   localparam int W2 = 2 * W;

   localparam logic [9:0]          CNT_MAX = 10'(DIV - 1);
   localparam logic [7:0]          GAIN8   = 8'(GAIN);
   localparam logic signed [W-1:0] GAIN_W  = {{(W-8){1'b0}}, GAIN8};
   localparam logic signed [W-1:0] SMAX    = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] SMIN    = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_SQUARE,
      S_SUB,
      S_GAIN,
      S_UPDATE
   } state_t;

   state_t              state;
   logic [9:0]          cnt;
   logic                cnt_tick;
   logic                tick;
   logic signed [W-1:0] sq_r;
   logic signed [W-1:0] sum_r;
   logic signed [W-1:0] prod_r;
   logic signed [W-1:0] filt_x_r;
   logic                filt_en_r;
   logic                busy_r;
   logic                overrun_r;
   logic signed [W-1:0] mul_a;
   logic signed [W-1:0] mul_b;
   logic signed [W2-1:0] mult;
   logic signed [W:0]   sum_w;

   // Both narrowing points share one 2W-bit view; sum is sign-extended before entry.
   function automatic logic signed [W-1:0] narrow(input logic signed [W2-1:0] v);
`ifdef OPAMP_SEQ_SAT_EN
      logic [W:0] top;
      top = v[W2-1:W-1];
      if (top == '0 || top == '1)
         return W'(v);
      else if (v[W2-1])
         return SMIN;
      else
         return SMAX;
`else
      return W'(v);
`endif
   endfunction

   assign cnt_tick = bus.run && (cnt == CNT_MAX);
   assign tick     = cnt_tick || bus.step;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (!bus.run || cnt == CNT_MAX)
         cnt <= '0;
      else
         cnt <= cnt + 10'd1;
   end

   // Single shared multiplier; operands are parked at zero outside the two multiply steps.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state)
         S_SQUARE: begin
            mul_a = bus.filt_y;
            mul_b = bus.filt_y;
         end
         S_GAIN: begin
            mul_a = sum_r;
            mul_b = GAIN_W;
         end
         default: ;
      endcase
   end

   assign mult  = mul_a * mul_b;
   assign sum_w = {bus.non_inv[W-1], bus.non_inv} - {sq_r[W-1], sq_r};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         sq_r      <= '0;
         sum_r     <= '0;
         prod_r    <= '0;
         filt_x_r  <= W'(1);
         filt_en_r <= 1'b0;
         busy_r    <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         filt_en_r <= 1'b0;
         // Set has priority over clear so a coincident overrun is never lost.
         if (tick && busy_r)
            overrun_r <= 1'b1;
         else if (bus.ovr_clr)
            overrun_r <= 1'b0;

         case (state)
            S_IDLE: begin
               if (tick) begin
                  state  <= S_SQUARE;
                  busy_r <= 1'b1;
               end
            end
            S_SQUARE: begin
               sq_r  <= narrow(mult);
               state <= S_SUB;
            end
            S_SUB: begin
               sum_r <= narrow(W2'(sum_w));
               state <= S_GAIN;
            end
            S_GAIN: begin
               prod_r <= narrow(mult);
               state  <= S_UPDATE;
            end
            S_UPDATE: begin
               filt_x_r  <= prod_r;
               filt_en_r <= 1'b1;
               busy_r    <= 1'b0;
               state     <= S_IDLE;
            end
            default: begin
               busy_r <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.filt_x  = filt_x_r;
   assign bus.filt_en = filt_en_r;
   assign bus.busy    = busy_r;
   assign bus.overrun = overrun_r;
endmodule
